cache_way_ctrl: RTL and testbench

//  Controller for a 4-way set-associative cache. Owns per-set tag, valid and dirty state plus the 3-bit tree-PLRU state.

---
 rtl/cache_way_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_cache_way_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_way_ctrl.sv
// cache_way_ctrl: tag/valid/dirty/PLRU controller for a 4-way set-associative cache.
// Sequences each CPU access through lookup, victim selection, optional dirty writeback,
// line fill and PLRU update. Data arrays are held outside this block.
//
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   req_valid/req_ready                CPU request handshake (ready only in idle)
//   req_op, req_index, req_tag         00 read, 01 write, 10 invalidate, 11 read
//   resp_valid, resp_hit, resp_way     one-cycle response; hit/way zero when not valid
//   mem_req_valid/mem_req_ready        memory transfer request handshake
//   mem_req_wb, mem_req_index,
//   mem_req_tag                        1 = victim writeback, 0 = fill; set and tag of transfer
//   mem_done                           completion pulse of the outstanding transfer
module cache_way_ctrl #(
   parameter int unsigned IDX_W = 4,
   parameter int unsigned TAG_W = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [IDX_W-1:0] req_index,
   input  logic [TAG_W-1:0] req_tag,
   output logic             resp_valid,
   output logic             resp_hit,
   output logic [1:0]       resp_way,
   output logic             mem_req_valid,
   input  logic             mem_req_ready,
   output logic             mem_req_wb,
   output logic [IDX_W-1:0] mem_req_index,
   output logic [TAG_W-1:0] mem_req_tag,
   input  logic             mem_done
);

   localparam int unsigned SETS = 2 ** IDX_W;

   localparam logic [2:0] StIdle     = 3'd0;
   localparam logic [2:0] StLookup   = 3'd1;
   localparam logic [2:0] StWbReq    = 3'd2;
   localparam logic [2:0] StWbWait   = 3'd3;
   localparam logic [2:0] StFillReq  = 3'd4;
   localparam logic [2:0] StFillWait = 3'd5;
   localparam logic [2:0] StResp     = 3'd6;

   localparam logic [1:0] OpWrite = 2'b01;
   localparam logic [1:0] OpInval = 2'b10;

   // Per-set state. Tags need no reset: a way is only trusted when its valid bit is set.
   logic [TAG_W-1:0] tag_mem_q [SETS][4];
   logic [3:0]       valid_q   [SETS];
   logic [3:0]       dirty_q   [SETS];
   logic [2:0]       plru_q    [SETS];

   logic [2:0]       state_q, state_d;
   logic             ready_en_q;
   logic [1:0]       op_q;
   logic [IDX_W-1:0] idx_q;
   logic [TAG_W-1:0] rtag_q;
   logic [1:0]       victim_q;
   logic             resp_hit_q;
   logic [1:0]       resp_way_q;

   logic             accept;
   logic             is_write, is_inval;
   logic [3:0]       set_valid, set_dirty;
   logic [3:0]       hit_vec;
   logic             any_hit;
   logic [1:0]       hit_way;
   logic [1:0]       victim_c;

   // Tree PLRU: A = [2], B = [1], C = [0]; touching a way points the tree away from it.
   function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [1:0] w);
      logic [2:0] r;
      r = p;
      case (w)
         2'd0:    begin r[2] = 1'b1; r[1] = 1'b1; end
         2'd1:    begin r[2] = 1'b1; r[1] = 1'b0; end
         2'd2:    begin r[2] = 1'b0; r[0] = 1'b1; end
         default: begin r[2] = 1'b0; r[0] = 1'b0; end
      endcase
      return r;
   endfunction

   function automatic logic [1:0] plru_victim(input logic [2:0] p);
      if (!p[2]) return p[1] ? 2'd1 : 2'd0;
      else       return p[0] ? 2'd3 : 2'd2;
   endfunction

   assign accept    = req_valid && req_ready;
   assign is_write  = (op_q == OpWrite);
   assign is_inval  = (op_q == OpInval);
   assign set_valid = valid_q[idx_q];
   assign set_dirty = dirty_q[idx_q];

   always_comb begin
      hit_vec = 4'b0000;
      for (int w = 0; w < 4; w++) begin
         hit_vec[w] = set_valid[w] && (tag_mem_q[idx_q][w] == rtag_q);
      end
   end

   assign any_hit = |hit_vec;

   // At most one way can match, so a priority encode is enough.
   always_comb begin
      hit_way = 2'd0;
      for (int w = 3; w >= 0; w--) begin
         if (hit_vec[w]) hit_way = 2'(w);
      end
   end

   // Lowest-numbered invalid way wins over the PLRU choice.
   always_comb begin
      victim_c = plru_victim(plru_q[idx_q]);
      if (!(&set_valid)) begin
         for (int w = 3; w >= 0; w--) begin
            if (!set_valid[w]) victim_c = 2'(w);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:     if (accept) state_d = StLookup;
         StLookup: begin
            if (any_hit || is_inval)                          state_d = StResp;
            else if (set_valid[victim_c] && set_dirty[victim_c]) state_d = StWbReq;
            else                                              state_d = StFillReq;
         end
         StWbReq:    if (mem_req_ready) state_d = StWbWait;
         StWbWait:   if (mem_done)      state_d = StFillReq;
         StFillReq:  if (mem_req_ready) state_d = StFillWait;
         StFillWait: if (mem_done)      state_d = StResp;
         StResp:     state_d = StIdle;
         default:    state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         ready_en_q <= 1'b0;
         op_q       <= 2'b00;
         idx_q      <= '0;
         rtag_q     <= '0;
         victim_q   <= 2'd0;
         resp_hit_q <= 1'b0;
         resp_way_q <= 2'd0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= 4'b0000;
            dirty_q[s] <= 4'b0000;
            plru_q[s]  <= 3'b000;
         end
      end else begin
         state_q    <= state_d;
         // Holds req_ready low for the first cycle after reset release.
         ready_en_q <= 1'b1;
         case (state_q)
            StIdle: begin
               if (accept) begin
                  op_q   <= req_op;
                  idx_q  <= req_index;
                  rtag_q <= req_tag;
               end
            end
            StLookup: begin
               if (any_hit) begin
                  resp_hit_q <= 1'b1;
                  resp_way_q <= hit_way;
                  if (is_inval) begin
                     valid_q[idx_q][hit_way] <= 1'b0;
                     dirty_q[idx_q][hit_way] <= 1'b0;
                  end else begin
                     plru_q[idx_q] <= plru_touch(plru_q[idx_q], hit_way);
                     if (is_write) dirty_q[idx_q][hit_way] <= 1'b1;
                  end
               end else begin
                  resp_hit_q <= 1'b0;
                  resp_way_q <= 2'd0;
                  victim_q   <= victim_c;
               end
            end
            StFillWait: begin
               if (mem_done) begin
                  tag_mem_q[idx_q][victim_q] <= rtag_q;
                  valid_q[idx_q][victim_q]   <= 1'b1;
                  dirty_q[idx_q][victim_q]   <= is_write;
                  plru_q[idx_q]              <= plru_touch(plru_q[idx_q], victim_q);
                  resp_way_q                 <= victim_q;
               end
            end
            default: ;
         endcase
      end
   end

   assign req_ready     = (state_q == StIdle) && ready_en_q;
   assign resp_valid    = (state_q == StResp);
   assign resp_hit      = resp_valid && resp_hit_q;
   assign resp_way      = resp_valid ? resp_way_q : 2'd0;

   assign mem_req_valid = (state_q == StWbReq) || (state_q == StFillReq);
   assign mem_req_wb    = (state_q == StWbReq);
   assign mem_req_index = mem_req_valid ? idx_q : '0;
   assign mem_req_tag   = (state_q == StWbReq)   ? tag_mem_q[idx_q][victim_q] :
                          (state_q == StFillReq) ? rtag_q : '0;

endmodule

// File: tb/tb_cache_way_ctrl.sv
// tb_cache_way_ctrl: directed self-checking bench for cache_way_ctrl.
module tb_cache_way_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [3:0]  req_index;
   logic [11:0] req_tag;
   logic        resp_valid;
   logic        resp_hit;
   logic [1:0]  resp_way;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_req_wb;
   logic [3:0]  mem_req_index;
   logic [11:0] mem_req_tag;
   logic        mem_done;

   int n_assert = 0;
   int n_fail   = 0;

   cache_way_ctrl #(
      .IDX_W (4),
      .TAG_W (12)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_op        (req_op),
      .req_index     (req_index),
      .req_tag       (req_tag),
      .resp_valid    (resp_valid),
      .resp_hit      (resp_hit),
      .resp_way      (resp_way),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_wb    (mem_req_wb),
      .mem_req_index (mem_req_index),
      .mem_req_tag   (mem_req_tag),
      .mem_done      (mem_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
      end
   endtask

   // Present a request and return just after the accepting edge.
   task automatic do_req(input logic [1:0] op, input logic [3:0] idx, input logic [11:0] tag);
      int n;
      n = 0;
      req_valid = 1'b1;
      req_op    = op;
      req_index = idx;
      req_tag   = tag;
      while (req_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("req_ready_seen", 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_mem(input logic wb, input logic [3:0] idx, input logic [11:0] tag);
      int n;
      n = 0;
      while (mem_req_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("mem_req_valid", 32'(mem_req_valid), 32'd1);
      check("mem_req_wb", 32'(mem_req_wb), 32'(wb));
      check("mem_req_index", 32'(mem_req_index), 32'(idx));
      check("mem_req_tag", 32'(mem_req_tag), 32'(tag));
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      check("mem_req_valid_drop", 32'(mem_req_valid), 32'd0);
   endtask

   task automatic mem_complete();
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
   endtask

   task automatic wait_resp(input logic hit, input logic [1:0] way);
      int n;
      n = 0;
      while (resp_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("resp_valid", 32'(resp_valid), 32'd1);
      check("resp_hit", 32'(resp_hit), 32'(hit));
      check("resp_way", 32'(resp_way), 32'(way));
      tick();
      check("resp_pulse_end", 32'(resp_valid), 32'd0);
   endtask

   // Lookup-only access (hit or invalidate): response exactly 2 cycles after accept.
   task automatic short_req(input logic [1:0] op, input logic [3:0] idx, input logic [11:0] tag,
                            input logic hit, input logic [1:0] way);
      do_req(op, idx, tag);
      check("short_lookup_resp", 32'(resp_valid), 32'd0);
      check("short_lookup_mem", 32'(mem_req_valid), 32'd0);
      tick();
      check("short_resp_mem", 32'(mem_req_valid), 32'd0);
      check("short_resp_valid", 32'(resp_valid), 32'd1);
      check("short_resp_hit", 32'(resp_hit), 32'(hit));
      check("short_resp_way", 32'(resp_way), 32'(way));
      tick();
      check("short_resp_end", 32'(resp_valid), 32'd0);
   endtask

   // Miss into a clean or invalid victim: fill only.
   task automatic miss_fill(input logic [1:0] op, input logic [3:0] idx, input logic [11:0] tag,
                            input logic [1:0] way);
      do_req(op, idx, tag);
      wait_mem(1'b0, idx, tag);
      mem_complete();
      wait_resp(1'b0, way);
   endtask

   initial begin
      rst_n         = 1'b0;
      req_valid     = 1'b0;
      req_op        = 2'b00;
      req_index     = 4'd0;
      req_tag       = 12'd0;
      mem_req_ready = 1'b0;
      mem_done      = 1'b0;

      // Reset state
      tick();
      tick();
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
      check("rst_mem_req_tag", 32'(mem_req_tag), 32'd0);
      rst_n = 1'b1;
      check("rst_release_ready_low", 32'(req_ready), 32'd0);
      tick();
      check("rst_release_ready_high", 32'(req_ready), 32'd1);

      // 1: cold miss fills way0, reread hits with 2-cycle latency
      miss_fill(2'b00, 4'd3, 12'h0A1, 2'd0);
      short_req(2'b00, 4'd3, 12'h0A1, 1'b1, 2'd0);

      // 2: fill idx5 ways 0..3, PLRU then picks way0; evicted tag 1 misses into way2
      miss_fill(2'b00, 4'd5, 12'h001, 2'd0);
      miss_fill(2'b00, 4'd5, 12'h002, 2'd1);
      miss_fill(2'b00, 4'd5, 12'h003, 2'd2);
      miss_fill(2'b00, 4'd5, 12'h004, 2'd3);
      miss_fill(2'b00, 4'd5, 12'h005, 2'd0);
      miss_fill(2'b11, 4'd5, 12'h001, 2'd2);
      short_req(2'b00, 4'd5, 12'h004, 1'b1, 2'd3);

      // 3: dirty way0 is the PLRU victim -> writeback of 0x10, then fill 0x20
      miss_fill(2'b01, 4'd2, 12'h010, 2'd0);
      miss_fill(2'b00, 4'd2, 12'h011, 2'd1);
      miss_fill(2'b00, 4'd2, 12'h012, 2'd2);
      miss_fill(2'b00, 4'd2, 12'h013, 2'd3);
      do_req(2'b00, 4'd2, 12'h020);
      wait_mem(1'b1, 4'd2, 12'h010);
      mem_complete();
      wait_mem(1'b0, 4'd2, 12'h020);
      mem_complete();
      wait_resp(1'b0, 2'd0);

      // 4: stalled fill request holds stable; stray mem_done pulses are ignored
      do_req(2'b00, 4'd7, 12'h055);
      tick();
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", 32'(mem_req_valid), 32'd1);
         check("stall_wb", 32'(mem_req_wb), 32'd0);
         check("stall_index", 32'(mem_req_index), 32'd7);
         check("stall_tag", 32'(mem_req_tag), 32'h055);
         mem_done = (i == 2);
         tick();
         mem_done = 1'b0;
      end
      check("stall_resp", 32'(resp_valid), 32'd0);
      mem_req_ready = 1'b1;
      mem_done      = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      mem_done      = 1'b0;
      check("ready_cycle_done_ignored", 32'(mem_req_valid), 32'd0);
      tick();
      check("fill_wait_no_resp", 32'(resp_valid), 32'd0);
      mem_complete();
      wait_resp(1'b0, 2'd0);

      // 5: invalidate hit, refill into the freed way, invalidate miss
      short_req(2'b10, 4'd5, 12'h001, 1'b1, 2'd2);
      miss_fill(2'b00, 4'd5, 12'h006, 2'd2);
      short_req(2'b10, 4'd5, 12'h7FF, 1'b0, 2'd0);

      // 6: reset during FILL_WAIT abandons the access and clears all valid state
      do_req(2'b00, 4'd3, 12'h0B2);
      wait_mem(1'b0, 4'd3, 12'h0B2);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("abort_mem_req_valid", 32'(mem_req_valid), 32'd0);
      check("abort_resp_valid", 32'(resp_valid), 32'd0);
      mem_complete();
      check("abort_late_done", 32'(resp_valid), 32'd0);
      miss_fill(2'b00, 4'd3, 12'h0A1, 2'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
